// File: rtl/vec_add_arbiter.sv
// Two-requester arbiter in front of a single sign-magnitude vector adder.
// One operation is in flight at a time: IDLE accepts, CALC computes, DONE holds the result.
module vec_add_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [56:0] req0_a,
    input  logic [56:0] req0_b,
    input  logic [56:0] req1_a,
    input  logic [56:0] req1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [56:0] rsp_data,
    output logic [2:0]  rsp_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rr;
    logic        r_owner;
    logic [56:0] r_a;
    logic [56:0] r_b;
    logic [56:0] r_data;
    logic [2:0]  r_ovf;

    logic        w_grant1;
    logic        w_accept;
    logic        w_rsp_take;
    logic [56:0] w_sum;
    logic [2:0]  w_sum_ovf;

    // Requester 1 wins when it is alone, or when both are valid and rr points at it.
    assign w_grant1   = req1_valid && (!req0_valid || ((FIXED_PRIO == 0) && r_rr));
    assign w_accept   = req0_ready || req1_ready;
    assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !w_grant1;
                    req1_ready = w_grant1;
                end
                if (req0_valid || req1_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (w_rsp_take) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_ovf   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner <= w_grant1;
                r_rr    <= !w_grant1;
                r_a     <= w_grant1 ? req1_a : req0_a;
                r_b     <= w_grant1 ? req1_b : req0_b;
            end
            if (r_state == S_CALC) begin
                r_data <= w_sum;
                r_ovf  <= w_sum_ovf;
            end
        end
    end

    // Component gi occupies bits [gi*19 +: 19]; gi=0 is z, gi=2 is x.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            logic [17:0] w_ma;
            logic [17:0] w_mb;
            logic        w_sa;
            logic        w_sb;
            logic [18:0] w_add;
            logic        w_a_ge;
            logic [17:0] w_diff;
            logic [17:0] w_mag;
            logic        w_sign;
            logic        w_ovf;

            // A zero magnitude is treated as positive so -0 never steers the sign.
            assign w_ma   = r_a[gi*19 +: 18];
            assign w_mb   = r_b[gi*19 +: 18];
            assign w_sa   = r_a[gi*19 + 18] && (w_ma != 18'd0);
            assign w_sb   = r_b[gi*19 + 18] && (w_mb != 18'd0);
            assign w_add  = {1'b0, w_ma} + {1'b0, w_mb};
            assign w_a_ge = (w_ma >= w_mb);
            assign w_diff = w_a_ge ? (w_ma - w_mb) : (w_mb - w_ma);

            always_comb begin
                w_mag  = w_add[17:0];
                w_sign = w_sa;
                w_ovf  = 1'b0;
                if (w_sa == w_sb) begin
                    if (w_add[18]) begin
                        w_mag = 18'h3FFFF;
                        w_ovf = 1'b1;
                    end
                end else begin
                    w_mag  = w_diff;
                    w_sign = w_a_ge ? w_sa : w_sb;
                end
                if (w_mag == 18'd0) begin
                    w_sign = 1'b0;
                end
            end

            assign w_sum[gi*19 +: 19] = {w_sign, w_mag};
            assign w_sum_ovf[gi]      = w_ovf;
        end
    endgenerate

    assign rsp0_valid = (r_state == S_DONE) && !r_owner;
    assign rsp1_valid = (r_state == S_DONE) && r_owner;
    assign rsp_data   = r_data;
    assign rsp_ovf    = r_ovf;
    assign busy       = (r_state != S_IDLE);

endmodule
